// File: rtl/chunk_serial_adder_pkg.sv
// chunk_serial_adder_pkg: shared types and sizing helpers for the
// chunked serial adder (FSM state enum, chunk count, counter width).
package chunk_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width is clog2 of the chunk count, never less than one bit.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder: combinational W-bit ripple adder.
// Ports: a, b operands; ci carry in; s sum; co carry out; c_msb_in carry into bit W-1.
module chunk_ripple_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: WIDTH-bit add/sub processed CHUNK bits per clock.
// Ports: clk, rst (async high); in_valid/in_ready + a, b, sub, cin;
// out_valid/out_ready + sum, carry, overflow, zero.
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int CW = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] KLAST = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cr;
    logic             carry_r;
    logic             ovf_r;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic             cmsb;

    assign ca = a_r[int'(k)*CHUNK +: CHUNK];
    assign cb = b_r[int'(k)*CHUNK +: CHUNK];

    chunk_ripple_adder #(
        .W(CHUNK)
    ) u_add (
        .a       (ca),
        .b       (cb),
        .ci      (cr),
        .s       (cs),
        .co      (co),
        .c_msb_in(cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cr      <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        // Subtract as a + ~b + ~cin: borrow-in inverts.
                        b_r   <= sub ? ~b : b;
                        cr    <= sub ? ~cin : cin;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[int'(k)*CHUNK +: CHUNK] <= cs;
                    cr <= co;
                    if (k == KLAST) begin
                        carry_r <= co;
                        ovf_r   <= cmsb ^ co;
                        state   <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign carry     = carry_r;
    assign overflow  = ovf_r;
    // Gated by out_valid so the reset value reads as 0.
    assign zero      = out_valid && (sum_r == '0);

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock. A registered carry links the chunks, and operands and results move over valid/ready handshakes. It is the area-reduced, wide-operand successor to the team's 16-bit combinational ripple adder. It sits in the ALU datapath where wide adds are needed and single-cycle timing cannot be met.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned/two's-complement.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b+cin; 1: a−b−cin (cin acts as borrow-in).
- cin  in  1  carry/borrow in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- carry  out  1  raw carry out of MSB; in sub mode 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Let N = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, sub, and b_eff = sub ? ~b : b. Initialise carry register to sub ? ~cin : cin. Set chunk counter k=0. Go to RUN.
  - RUN: each cycle, add chunk k of a, chunk k of b_eff and the carry register through one CHUNK-bit ripple adder. Write the result to sum bits [k·CHUNK +: CHUNK]. Update the carry register. When k==N−1, also capture the carry into the MSB and go to DONE. Otherwise k increments. Inputs are ignored in RUN.
  - DONE: out_valid=1. sum, carry, overflow and zero are stable. On out_ready, go to IDLE.
- overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), registered at the last chunk.
- zero is computed from the final registered sum and is meaningful only while out_valid=1.
- Arithmetic is modulo 2^WIDTH. There are no saturating modes.
- Only one operation is in flight at a time. There is no input buffering.
- Reset at any time, including mid-RUN or in DONE with out_valid high:
  - State goes to IDLE; the partial result is discarded.
  - in_ready=1, out_valid=0.
  - sum=0, carry=0, overflow=0, zero=0.
  - Counter and carry register are 0.

## Timing
- Accept edge → out_valid high exactly N cycles later (N RUN cycles). For WIDTH=16, CHUNK=4 this is 4.
- CHUNK=WIDTH gives N=1: a single RUN cycle.
- Results hold unchanged while out_valid && !out_ready, for any number of cycles.
- The DONE→IDLE transition takes one edge. in_ready rises the cycle after the out_ready handshake. Back-to-back throughput is one result per N+2 cycles.
- in_ready and out_valid are never both 1.
- in_ready and out_valid are driven from state only, with no combinational path from in_valid or out_ready.
- in_valid asserted outside IDLE has no effect. The producer holds its operands until in_ready.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - a helper constant function computing N and the counter width, clog2 of N, minimum 1.
- One combinational sub-module, chunk_ripple_adder:
  - parameter W;
  - ports a, b, ci, s, co, plus c_msb_in (carry into the top bit, used for overflow).
- Top level holds the FSM, counter, operand/carry registers and sum assembly. Chunk selection uses indexed part-selects.

## Test plan
All at WIDTH=16, CHUNK=4.
- 0xFFFF + 0x0001, cin=0, sub=0 → out_valid 4 cycles after accept; sum=0x0000, carry=1, zero=1, overflow=0.
- 0x7FFF + 0x0001 → sum=0x8000, carry=0, overflow=1, zero=0.
- sub=1, 0x0005 − 0x0007, cin=0 → sum=0xFFFE, carry=0, overflow=0; with cin=1 → sum=0xFFFD.
- 0x1234 + 0x4321 with out_ready low for 5 cycles → sum=0x5555 held steady, in_ready=0 throughout; in_ready=1 one cycle after the out_ready handshake.
- Assert rst asynchronously during the 2nd RUN cycle → immediately in_ready=1, out_valid=0, sum=0. The next op 0x0001+0x0001 gives 0x0002.
- Random soak at WIDTH=32, CHUNK=8 and WIDTH=8, CHUNK=8 → every result matches a golden (a ± b ± cin) mod 2^WIDTH, and carry and overflow match a reference model.
